// File: rtl/des_key_schedule.sv
// DES key schedule front end: applies PC-1 to the key, then presents the
// sixteen rotated C/D half pairs one per accepted round, in encrypt or decrypt order.
module des_key_schedule (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:64] key,
    input  logic        decrypt,
    input  logic        round_ready,
    output logic        busy,
    output logic        round_valid,
    output logic [3:0]  round_idx,
    output logic [1:28] c_out,
    output logic [1:28] d_out,
    output logic        done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic        dec_q;
    logic [1:28] c0;
    logic [1:28] d0;
    logic [4:0]  next_r;
    logic        next_two;

    // PC-1: bit positions of the key feeding C0 and D0, parity bits dropped
    assign c0 = {key[57], key[49], key[41], key[33], key[25], key[17], key[9],
                 key[1],  key[58], key[50], key[42], key[34], key[26], key[18],
                 key[10], key[2],  key[59], key[51], key[43], key[35], key[27],
                 key[19], key[11], key[3],  key[60], key[52], key[44], key[36]};
    assign d0 = {key[63], key[55], key[47], key[39], key[31], key[23], key[15],
                 key[7],  key[62], key[54], key[46], key[38], key[30], key[22],
                 key[14], key[6],  key[61], key[53], key[45], key[37], key[29],
                 key[21], key[13], key[5],  key[28], key[20], key[12], key[4]};

    // Schedule entry used to step from the presented round to the next one.
    // Decrypt walks the encrypt schedule backwards, undoing S[16] first.
    assign next_r   = dec_q ? (5'd16 - {1'b0, round_idx}) : ({1'b0, round_idx} + 5'd2);
    assign next_two = !((next_r == 5'd1) || (next_r == 5'd2) ||
                        (next_r == 5'd9) || (next_r == 5'd16));

    function automatic logic [1:28] rot(input logic [1:28] x, input logic left,
                                        input logic two);
        if (left)
            return two ? {x[3:28], x[1:2]} : {x[2:28], x[1]};
        else
            return two ? {x[27:28], x[1:26]} : {x[28], x[1:27]};
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            dec_q       <= 1'b0;
            busy        <= 1'b0;
            round_valid <= 1'b0;
            round_idx   <= 4'd0;
            c_out       <= '0;
            d_out       <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= RUN;
                        dec_q       <= decrypt;
                        busy        <= 1'b1;
                        round_valid <= 1'b1;
                        round_idx   <= 4'd0;
                        // C16 equals C0, so decrypt round 1 is the unrotated pair
                        c_out       <= decrypt ? c0 : rot(c0, 1'b1, 1'b0);
                        d_out       <= decrypt ? d0 : rot(d0, 1'b1, 1'b0);
                    end
                end
                RUN: begin
                    if (round_ready) begin
                        if (round_idx == 4'd15) begin
                            state       <= IDLE;
                            busy        <= 1'b0;
                            round_valid <= 1'b0;
                            done        <= 1'b1;
                        end else begin
                            round_idx <= round_idx + 4'd1;
                            c_out     <= rot(c_out, !dec_q, next_two);
                            d_out     <= rot(d_out, !dec_q, next_two);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule: a driver issues schedules and pushes the
// expected rounds; a monitor pops and compares each accepted round.
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] key;
    logic        decrypt;
    logic        round_ready;
    logic        busy;
    logic        round_valid;
    logic [3:0]  round_idx;
    logic [27:0] c_out;
    logic [27:0] d_out;
    logic        done;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    logic [59:0] exp_q[$];
    logic [59:0] mon_item;

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_B = 64'hFEDCBA9876543210;

    // C_r / D_r for KEY_A, index 0 = C0/D0
    localparam logic [27:0] CT [17] = '{
        28'hF0CCAAF, 28'hE19955F, 28'hC332ABF, 28'h0CCAAFF, 28'h332ABFC,
        28'hCCAAFF0, 28'h32ABFC3, 28'hCAAFF0C, 28'h2ABFC33, 28'h557F866,
        28'h55FE199, 28'h57F8665, 28'h5FE1995, 28'h7F86655, 28'hFE19955,
        28'hF866557, 28'hF0CCAAF};
    localparam logic [27:0] DT [17] = '{
        28'h556678F, 28'hAACCF1E, 28'h5599E3D, 28'h56678F5, 28'h599E3D5,
        28'h6678F55, 28'h99E3D55, 28'h678F556, 28'h9E3D559, 28'h3C7AAB3,
        28'hF1EAACC, 28'hC7AAB33, 28'h1EAACCF, 28'h7AAB33C, 28'hEAACCF1,
        28'hAAB33C7, 28'h556678F};

    des_key_schedule dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .key         (key),
        .decrypt     (decrypt),
        .round_ready (round_ready),
        .busy        (busy),
        .round_valid (round_valid),
        .round_idx   (round_idx),
        .c_out       (c_out),
        .d_out       (d_out),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a round is accepted at the next rising edge when valid and ready are high
    always @(negedge clk) begin
        if (rst_n && round_valid && round_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_round: got idx %0d c %0h d %0h with empty queue",
                         round_idx, c_out, d_out);
            end else begin
                mon_item = exp_q.pop_front();
                chk("round", {4'h0, round_idx, c_out, d_out}, {4'h0, mon_item});
            end
        end
        if (done) done_cnt++;
    end

    task automatic push_sched(input logic dec);
        logic [3:0] kk;
        for (int k = 0; k < 16; k++) begin
            kk = 4'(k);
            if (dec) exp_q.push_back({kk, CT[16-k], DT[16-k]});
            else     exp_q.push_back({kk, CT[k+1], DT[k+1]});
        end
    endtask

    // Drives start for one cycle; returns just after the start-accept edge
    task automatic issue(input logic [63:0] k, input logic dec);
        @(posedge clk); #1;
        key = k;
        decrypt = dec;
        start = 1'b1;
        push_sched(dec);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idx(input logic [3:0] i);
        int n;
        for (n = 0; n < 64; n++) begin
            @(posedge clk); #1;
            if (round_valid && round_idx == i) break;
        end
        chk("wait_idx_timeout", 64'(n < 64), 64'd1);
    endtask

    // Returns at the negedge inside the done cycle
    task automatic wait_done(input int budget);
        int n;
        for (n = 0; n < budget; n++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("done_timeout", 64'(n < budget), 64'd1);
        chk("done_busy", 64'(busy), 64'd0);
        chk("done_valid", 64'(round_valid), 64'd0);
    endtask

    int saved_done;

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        key = KEY_A;
        decrypt = 1'b0;
        round_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        start = 1'b0;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_valid", 64'(round_valid), 64'd0);
        chk("reset_outs", {4'h0, round_idx, c_out, d_out}, 64'd0);
        chk("reset_done", 64'(done), 64'd0);

        // Encrypt with exact latency and done timing
        issue(KEY_A, 1'b0);
        for (int n = 1; n <= 17; n++) begin
            @(negedge clk);
            if (n == 1) begin
                chk("lat_valid", 64'(round_valid), 64'd1);
                chk("lat_busy", 64'(busy), 64'd1);
                chk("lat_c1", 64'(c_out), 64'(CT[1]));
                chk("lat_d1", 64'(d_out), 64'(DT[1]));
            end
            if (n < 17) chk("done_early", 64'(done), 64'd0);
            else begin
                chk("done_cycle17", 64'(done), 64'd1);
                chk("done17_busy", 64'(busy), 64'd0);
                chk("done17_valid", 64'(round_valid), 64'd0);
                chk("hold_c16", 64'(c_out), 64'(CT[16]));
                chk("hold_d16", 64'(d_out), 64'(DT[16]));
            end
        end
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);

        // Decrypt order
        issue(KEY_A, 1'b1);
        wait_done(40);

        // Backpressure for three edges at round_idx 4
        issue(KEY_A, 1'b0);
        wait_idx(4'd4);
        round_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_valid", 64'(round_valid), 64'd1);
            chk("stall_idx", 64'(round_idx), 64'd4);
            chk("stall_c", 64'(c_out), 64'(CT[5]));
            chk("stall_d", 64'(d_out), 64'(DT[5]));
        end
        @(posedge clk); #1;
        round_ready = 1'b1;
        wait_done(40);

        // start and key change while busy are ignored
        issue(KEY_A, 1'b0);
        wait_idx(4'd7);
        start = 1'b1;
        key = KEY_B;
        decrypt = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(40);
        @(negedge clk);
        chk("no_ghost_start", 64'(round_valid), 64'd0);

        // Reset mid-schedule, with start held during the reset cycle
        issue(KEY_A, 1'b0);
        wait_idx(4'd9);
        saved_done = done_cnt;
        rst_n = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        start = 1'b0;
        exp_q.delete();
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_valid", 64'(round_valid), 64'd0);
        chk("abort_outs", {4'h0, round_idx, c_out, d_out}, 64'd0);
        repeat (3) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt), 64'(saved_done));
        issue(KEY_A, 1'b0);
        wait_done(40);

        // Back-to-back: start held through done
        @(posedge clk); #1;
        key = KEY_A;
        decrypt = 1'b0;
        start = 1'b1;
        push_sched(1'b0);
        push_sched(1'b0);
        wait_done(40);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("b2b_valid", 64'(round_valid), 64'd1);
        chk("b2b_idx", 64'(round_idx), 64'd0);
        chk("b2b_c1", 64'(c_out), 64'(CT[1]));
        chk("b2b_d1", 64'(d_out), 64'(DT[1]));
        wait_done(40);

        repeat (3) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        chk("done_count", 64'(done_cnt), 64'd7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
